// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request bus and FIFO write port seen by the write arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            REQ;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            GNT;
  logic [NUM_REQ-1:0]            ACK;
  logic                          FIFO_FULL;
  logic                          FIFO_WR_EN;
  logic [DATA_WIDTH-1:0]         FIFO_DATA_IN;
  modport master (
    input  REQ, REQ_DATA, FIFO_FULL,
    output GNT, ACK, FIFO_WR_EN, FIFO_DATA_IN
  );
  modport slave (
    output REQ, REQ_DATA, FIFO_FULL,
    input  GNT, ACK, FIFO_WR_EN, FIFO_DATA_IN
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst write arbiter in front of a shared FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input logic FCLK,
  input logic FRST,
  fifo_wr_arbiter_if.master bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick, k;
  logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
  logic             found, busy, xfer;
  logic [NUM_REQ-1:0] owner_oh;
  assign busy     = state_q == BUSY;
  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign xfer     = busy && bus.REQ[owner_q] && !bus.FIFO_FULL && !FRST;
  assign bus.GNT          = (busy && !FRST) ? owner_oh : '0;
  assign bus.ACK          = xfer ? owner_oh : '0;
  assign bus.FIFO_WR_EN   = xfer;
  assign bus.FIFO_DATA_IN = busy ? bus.REQ_DATA[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && bus.REQ[k]) begin
        pick  = k;
        found = 1'b1;
      end
    end
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (!busy) begin
      if (found) begin
        state_d     = BUSY;
        owner_d     = pick;
        burst_cnt_d = '0;
      end
    end else if (!bus.REQ[owner_q] || (xfer && burst_cnt_q == CW'(MAX_BURST - 1))) begin
      // releasing owner drops to lowest priority for the next arbitration
      state_d     = IDLE;
      rr_ptr_d    = IDX_W'((int'(owner_q) + 1) % NUM_REQ);
      burst_cnt_d = '0;
    end else if (xfer) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge FCLK) begin
    if (FRST) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench; a producer/arbiter model predicts each cycle's outputs
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, MB = 4;
  typedef struct {
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          wr;
    logic [DW-1:0] data;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .FCLK(clk), .FRST(rst), .bus(bus.master)
  );
  exp_t exp_q[$];
  int errors = 0, checks = 0, dut_writes = 0;
  int m_owner = -1, m_prio = 0, m_sent = 0;
  logic [DW-1:0] pdata[N];
  // one cycle of stimulus; the model predicts this cycle's outputs, then advances
  task automatic step(input logic [N-1:0] r, input logic f, input logic rs);
    exp_t e;
    bit wrote;
    @(posedge clk);
    #1;
    rst = rs;
    bus.REQ = r;
    bus.FIFO_FULL = f;
    for (int i = 0; i < N; i++) bus.REQ_DATA[i*DW +: DW] = pdata[i];
    e.gnt = '0; e.ack = '0; e.wr = 1'b0; e.data = '0;
    wrote = 0;
    if (m_owner >= 0 && !rs) begin
      e.gnt = N'(1) << m_owner;
      wrote = r[m_owner] && !f;
      e.wr = wrote;
      e.ack = wrote ? e.gnt : '0;
      e.data = pdata[m_owner];
    end
    exp_q.push_back(e);
    if (rs) begin
      m_owner = -1; m_prio = 0; m_sent = 0;
    end else if (m_owner < 0) begin
      for (int j = 0; j < N; j++)
        if (m_owner < 0 && r[(m_prio + j) % N]) m_owner = (m_prio + j) % N;
      m_sent = 0;
    end else begin
      if (wrote) begin
        pdata[m_owner] = pdata[m_owner] + 8'd1;
        m_sent++;
      end
      if (!r[m_owner] || m_sent == MB) begin
        m_prio = (m_owner + 1) % N;
        m_owner = -1;
        m_sent = 0;
      end
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (bus.FIFO_WR_EN) dut_writes++;
      checks++;
      if (bus.GNT !== e.gnt) begin
        errors++; $display("FAIL gnt t=%0t got=%b want=%b", $time, bus.GNT, e.gnt);
      end
      checks++;
      if (bus.ACK !== e.ack) begin
        errors++; $display("FAIL ack t=%0t got=%b want=%b", $time, bus.ACK, e.ack);
      end
      checks++;
      if (bus.FIFO_WR_EN !== e.wr) begin
        errors++; $display("FAIL wr_en t=%0t got=%b want=%b", $time, bus.FIFO_WR_EN, e.wr);
      end
      if (e.wr) begin
        checks++;
        if (bus.FIFO_DATA_IN !== e.data) begin
          errors++; $display("FAIL data t=%0t got=%h want=%h", $time, bus.FIFO_DATA_IN, e.data);
        end
      end
    end
  end
  task automatic check_count(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++; $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  initial begin
    int base;
    bus.REQ = '0; bus.FIFO_FULL = 1'b0; bus.REQ_DATA = '0;
    for (int i = 0; i < N; i++) pdata[i] = 8'hA0 + 8'(i);
    // reset held with everyone requesting, then first grant to producer 0
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    // sole requester: 9 words in 12 cycles (burst, bubble, burst, bubble, 1)
    base = dut_writes;
    repeat (12) step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check_count("sole_req_writes", dut_writes - base, 9);
    step(4'b0000, 1'b0, 1'b0);
    // all producers request: rotating bursts of 4
    base = dut_writes;
    repeat (30) step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check_count("all_req_writes", dut_writes - base, 24);
    repeat (2) step(4'b0000, 1'b0, 1'b0);
    // reset clears rr pointer; owner 0 stalls on FULL mid-burst
    step(4'b0000, 1'b0, 1'b1);
    repeat (3) step(4'b0001, 1'b0, 1'b0);
    repeat (5) step(4'b0001, 1'b1, 1'b0);
    repeat (4) step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    // owner 1 withdraws after one write, producer 2 takes over
    repeat (2) step(4'b0010, 1'b0, 1'b0);
    repeat (4) step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    // reset mid-burst of owner 3, then arbitration restarts at producer 0
    step(4'b0000, 1'b0, 1'b1);
    repeat (3) step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b1);
    repeat (4) step(4'b1111, 1'b0, 1'b0);
    // randomized traffic with stalls, withdrawals and occasional reset
    for (int c = 0; c < 400; c++)
      step(N'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
    step(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check_count("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
